// File: rtl/core_mul_sched.sv
`default_nettype none
// ============================================================================
//  Module   : core_mul_sched
//  Purpose  : Shares one core_mul multiplier between the two issue lanes of
//             the dual-issue core. Arbitrates lane requests with lane 0
//             priority, latches operands, runs the start/ready handshake and
//             serialises the 32/64-bit result onto one writeback port.
//             Flushes never abort the multiplier: an operation that has been
//             handed to core_mul is always drained to completion.
//  Revision : 1.0 - initial release
// ============================================================================
module core_mul_sched #(
    parameter int W   = 32,
    parameter int R_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic [1:0]       req,
    output logic [1:0]       gnt,
    input  logic [2*W-1:0]   op_a,
    input  logic [2*W-1:0]   op_b,
    input  logic [2*W-1:0]   op_c_hi,
    input  logic [2*W-1:0]   op_c_lo,
    input  logic [1:0]       op_long,
    input  logic [1:0]       op_add,
    input  logic [1:0]       op_sig,
    input  logic [2*R_W-1:0] op_rd_lo,
    input  logic [2*R_W-1:0] op_rd_hi,
    output logic             mul_start,
    output logic [W-1:0]     mul_a,
    output logic [W-1:0]     mul_b,
    output logic [W-1:0]     mul_c_hi,
    output logic [W-1:0]     mul_c_lo,
    output logic             mul_long,
    output logic             mul_add,
    output logic             mul_signed,
    input  logic [W-1:0]     mul_q_hi,
    input  logic [W-1:0]     mul_q_lo,
    input  logic             mul_ready,
    output logic             wb_valid,
    output logic [R_W-1:0]   wb_r,
    output logic [W-1:0]     wb_value,
    input  logic             wb_ack,
    output logic             busy
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_WB_LO = 3'd3,
        S_WB_HI = 3'd4,
        S_DRAIN = 3'd5
    } state_t;

    state_t         state_q;

    // Latched operation (held stable from ISSUE until the result is captured)
    logic [W-1:0]   a_q;
    logic [W-1:0]   b_q;
    logic [W-1:0]   c_hi_q;
    logic [W-1:0]   c_lo_q;
    logic           long_q;
    logic           add_q;
    logic           sig_q;
    logic [R_W-1:0] rd_lo_q;
    logic [R_W-1:0] rd_hi_q;

    // High result word parked here while the low word is being written back
    logic [W-1:0]   res_hi_q;

    // Registered outputs
    logic           start_q;
    logic           wb_valid_q;
    logic [R_W-1:0] wb_r_q;
    logic [W-1:0]   wb_value_q;
    logic           busy_q;

    // Lane selected by the arbiter for this cycle
    logic           sel_lane1;
    logic [W-1:0]   sel_a;
    logic [W-1:0]   sel_b;
    logic [W-1:0]   sel_c_hi;
    logic [W-1:0]   sel_c_lo;
    logic           sel_long;
    logic           sel_add;
    logic           sel_sig;
    logic [R_W-1:0] sel_rd_lo;
    logic [R_W-1:0] sel_rd_hi;

    // Fixed-priority grant: only while idle, not flushing and out of reset
    always_comb begin
        gnt = 2'b00;
        if (rst_n && (state_q == S_IDLE) && !flush) begin
            if (req[0]) begin
                gnt = 2'b01;
            end else if (req[1]) begin
                gnt = 2'b10;
            end
        end
    end

    assign sel_lane1 = gnt[1];
    assign sel_a     = sel_lane1 ? op_a[2*W-1:W]        : op_a[W-1:0];
    assign sel_b     = sel_lane1 ? op_b[2*W-1:W]        : op_b[W-1:0];
    assign sel_c_hi  = sel_lane1 ? op_c_hi[2*W-1:W]     : op_c_hi[W-1:0];
    assign sel_c_lo  = sel_lane1 ? op_c_lo[2*W-1:W]     : op_c_lo[W-1:0];
    assign sel_long  = sel_lane1 ? op_long[1]           : op_long[0];
    assign sel_add   = sel_lane1 ? op_add[1]            : op_add[0];
    assign sel_sig   = sel_lane1 ? op_sig[1]            : op_sig[0];
    assign sel_rd_lo = sel_lane1 ? op_rd_lo[2*R_W-1:R_W] : op_rd_lo[R_W-1:0];
    assign sel_rd_hi = sel_lane1 ? op_rd_hi[2*R_W-1:R_W] : op_rd_hi[R_W-1:0];

    // Scheduler FSM: grant/latch, start pulse, result wait, two-beat writeback, drain
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            a_q        <= '0;
            b_q        <= '0;
            c_hi_q     <= '0;
            c_lo_q     <= '0;
            long_q     <= 1'b0;
            add_q      <= 1'b0;
            sig_q      <= 1'b0;
            rd_lo_q    <= '0;
            rd_hi_q    <= '0;
            res_hi_q   <= '0;
            start_q    <= 1'b0;
            wb_valid_q <= 1'b0;
            wb_r_q     <= '0;
            wb_value_q <= '0;
            busy_q     <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (gnt != 2'b00) begin
                        a_q     <= sel_a;
                        b_q     <= sel_b;
                        c_hi_q  <= sel_c_hi;
                        c_lo_q  <= sel_c_lo;
                        long_q  <= sel_long;
                        add_q   <= sel_add;
                        sig_q   <= sel_sig;
                        rd_lo_q <= sel_rd_lo;
                        rd_hi_q <= sel_rd_hi;
                        start_q <= 1'b1;
                        busy_q  <= 1'b1;
                        state_q <= S_ISSUE;
                    end
                end

                S_ISSUE: begin
                    // The start pulse is already on the wire, so a flush here
                    // can only turn the operation into a drain.
                    start_q <= 1'b0;
                    state_q <= flush ? S_DRAIN : S_WAIT;
                end

                S_WAIT: begin
                    if (flush) begin
                        if (mul_ready) begin
                            busy_q  <= 1'b0;
                            state_q <= S_IDLE;
                        end else begin
                            state_q <= S_DRAIN;
                        end
                    end else if (mul_ready) begin
                        res_hi_q   <= mul_q_hi;
                        wb_valid_q <= 1'b1;
                        wb_r_q     <= rd_lo_q;
                        wb_value_q <= mul_q_lo;
                        state_q    <= S_WB_LO;
                    end
                end

                S_WB_LO: begin
                    if (wb_ack) begin
                        if (long_q) begin
                            wb_r_q     <= rd_hi_q;
                            wb_value_q <= res_hi_q;
                            state_q    <= S_WB_HI;
                        end else begin
                            wb_valid_q <= 1'b0;
                            wb_r_q     <= '0;
                            wb_value_q <= '0;
                            busy_q     <= 1'b0;
                            state_q    <= S_IDLE;
                        end
                    end
                end

                S_WB_HI: begin
                    if (wb_ack) begin
                        wb_valid_q <= 1'b0;
                        wb_r_q     <= '0;
                        wb_value_q <= '0;
                        busy_q     <= 1'b0;
                        state_q    <= S_IDLE;
                    end
                end

                S_DRAIN: begin
                    if (mul_ready) begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end

                default: begin
                    start_q    <= 1'b0;
                    wb_valid_q <= 1'b0;
                    busy_q     <= 1'b0;
                    state_q    <= S_IDLE;
                end
            endcase
        end
    end

    assign mul_start  = start_q;
    assign mul_a      = a_q;
    assign mul_b      = b_q;
    assign mul_c_hi   = c_hi_q;
    assign mul_c_lo   = c_lo_q;
    assign mul_long   = long_q;
    assign mul_add    = add_q;
    assign mul_signed = sig_q;
    assign wb_valid   = wb_valid_q;
    assign wb_r       = wb_r_q;
    assign wb_value   = wb_value_q;
    assign busy       = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_core_mul_sched.sv
`default_nettype none
// ============================================================================
//  Module   : tb_core_mul_sched
//  Purpose  : Self-checking bench for core_mul_sched with a behavioural
//             core_mul stand-in of programmable latency.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_core_mul_sched;

    localparam int W   = 32;
    localparam int R_W = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             flush = 1'b0;
    logic [1:0]       req = 2'b00;
    logic [1:0]       gnt;
    logic [2*W-1:0]   op_a = '0, op_b = '0, op_c_hi = '0, op_c_lo = '0;
    logic [1:0]       op_long = '0, op_add = '0, op_sig = '0;
    logic [2*R_W-1:0] op_rd_lo = '0, op_rd_hi = '0;
    logic             mul_start;
    logic [W-1:0]     mul_a, mul_b, mul_c_hi, mul_c_lo;
    logic             mul_long, mul_add, mul_signed;
    logic [W-1:0]     mul_q_hi = '0, mul_q_lo = '0;
    logic             mul_ready = 1'b0;
    logic             wb_valid;
    logic [R_W-1:0]   wb_r;
    logic [W-1:0]     wb_value;
    logic             wb_ack = 1'b0;
    logic             busy;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [1:0]  req;
        logic [31:0] a, b, chi, clo;
        logic        lng, add, sig;
        logic [3:0]  rlo, rhi;
        int          n;
        int          stall;
        bit          flw;
        logic [31:0] elo, ehi;
    } op_t;

    core_mul_sched #(.W(W), .R_W(R_W)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .req(req), .gnt(gnt),
        .op_a(op_a), .op_b(op_b), .op_c_hi(op_c_hi), .op_c_lo(op_c_lo),
        .op_long(op_long), .op_add(op_add), .op_sig(op_sig),
        .op_rd_lo(op_rd_lo), .op_rd_hi(op_rd_hi),
        .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
        .mul_c_hi(mul_c_hi), .mul_c_lo(mul_c_lo),
        .mul_long(mul_long), .mul_add(mul_add), .mul_signed(mul_signed),
        .mul_q_hi(mul_q_hi), .mul_q_lo(mul_q_lo), .mul_ready(mul_ready),
        .wb_valid(wb_valid), .wb_r(wb_r), .wb_value(wb_value),
        .wb_ack(wb_ack), .busy(busy)
    );

    always #5 clk = ~clk;

    // Architectural multiply-accumulate result
    function automatic logic [63:0] ref_mul(input logic [31:0] a, b, chi, clo,
                                            input logic lng, add, sig);
        logic [63:0] p, acc;
        if (sig) p = {{32{a[31]}}, a} * {{32{b[31]}}, b};
        else     p = {32'b0, a} * {32'b0, b};
        if (!add)    acc = 64'd0;
        else if (lng) acc = {chi, clo};
        else         acc = {32'b0, clo};
        return p + acc;
    endfunction

    // core_mul stand-in: ready for one cycle, mul_lat cycles after the start cycle
    int          mul_lat = 2;
    int          rem = 0;
    logic        st_seen, rst_seen;
    logic [63:0] pend = '0;
    always begin
        @(negedge clk);
        st_seen  = mul_start;
        rst_seen = rst_n;
        if (mul_start)
            pend = ref_mul(mul_a, mul_b, mul_c_hi, mul_c_lo, mul_long, mul_add, mul_signed);
        @(posedge clk);
        #1;
        if (!rst_seen)    rem = 0;
        else if (st_seen) rem = mul_lat;
        else if (rem > 0) rem = rem - 1;
        mul_ready = (rem == 1);
        mul_q_hi  = (rem == 1) ? pend[63:32] : $urandom();
        mul_q_lo  = (rem == 1) ? pend[31:0]  : $urandom();
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic scramble();
        op_a     = {$urandom(), $urandom()};
        op_b     = {$urandom(), $urandom()};
        op_c_hi  = {$urandom(), $urandom()};
        op_c_lo  = {$urandom(), $urandom()};
        op_long  = 2'($urandom_range(0, 3));
        op_add   = 2'($urandom_range(0, 3));
        op_sig   = 2'($urandom_range(0, 3));
        op_rd_lo = 8'($urandom_range(0, 255));
        op_rd_hi = 8'($urandom_range(0, 255));
    endtask

    // Present op t on the lane its request pattern will win; other lane random
    task automatic drive_op(input op_t t);
        scramble();
        if (t.req[0]) begin
            op_a[31:0] = t.a;   op_b[31:0] = t.b;
            op_c_hi[31:0] = t.chi; op_c_lo[31:0] = t.clo;
            op_long[0] = t.lng; op_add[0] = t.add; op_sig[0] = t.sig;
            op_rd_lo[3:0] = t.rlo; op_rd_hi[3:0] = t.rhi;
        end else begin
            op_a[63:32] = t.a;  op_b[63:32] = t.b;
            op_c_hi[63:32] = t.chi; op_c_lo[63:32] = t.clo;
            op_long[1] = t.lng; op_add[1] = t.add; op_sig[1] = t.sig;
            op_rd_lo[7:4] = t.rlo; op_rd_hi[7:4] = t.rhi;
        end
        mul_lat = t.n;
        req     = t.req;
    endtask

    task automatic wait_grant(input op_t t);
        int c;
        c = 0;
        #3;
        while (gnt == 2'b00 && c < 50) begin
            tick(); #3; c++;
        end
        chk("gnt", gnt, t.req[0] ? 2'b01 : 2'b10);
    endtask

    task automatic write_beat(input string nm, input logic [3:0] rd, input logic [31:0] val,
                              input int stall, input bit flw);
        chk({nm, "_valid"}, wb_valid, 1'b1);
        chk({nm, "_r"}, wb_r, rd);
        chk({nm, "_value"}, wb_value, val);
        for (int k = 0; k < stall; k++) begin
            flush  = flw;
            wb_ack = 1'b0;
            tick();
            flush = 1'b0;
            #3;
            chk({nm, "_stall_valid"}, wb_valid, 1'b1);
            chk({nm, "_stall_r"}, wb_r, rd);
            chk({nm, "_stall_value"}, wb_value, val);
        end
        wb_ack = 1'b1;
        tick();
        wb_ack = 1'b0;
        #3;
    endtask

    // Called at the sample point of the grant cycle; runs the op to completion
    task automatic finish_op(input op_t t, input int stall, input bit flw);
        int c, starts;
        tick();
        req = 2'b00;
        scramble();
        #3;
        chk("issue_start", mul_start, 1'b1);
        chk("issue_busy", busy, 1'b1);
        chk("mul_a", mul_a, t.a);
        chk("mul_b", mul_b, t.b);
        chk("mul_c", {mul_c_hi, mul_c_lo}, {t.chi, t.clo});
        chk("mul_ctl", {mul_long, mul_add, mul_signed}, {t.lng, t.add, t.sig});
        c = 1;
        starts = 0;
        while (!wb_valid && c < 60) begin
            tick(); #3; c++;
            if (mul_start) starts++;
        end
        chk("single_start", starts, 0);
        chk("latency", c, 2 + t.n);
        write_beat("lo", t.rlo, t.elo, stall, flw);
        if (t.lng) write_beat("hi", t.rhi, t.ehi, stall, flw);
        chk("idle_after", {busy, wb_valid}, 2'b00);
    endtask

    op_t tbl[7];
    op_t t, t1;

    initial begin
        int saw11, g1, ackc, c, starts, seenwb;
        logic [63:0] r;

        tbl[0] = '{2'b01, 32'd7, 32'd6, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 4'd3, 4'd0, 2, 0, 1'b0, 32'd42, 32'd0};
        tbl[1] = '{2'b01, 32'hFFFFFFFE, 32'd3, 32'd0, 32'd0, 1'b1, 1'b0, 1'b1, 4'd4, 4'd5, 2, 3, 1'b0, 32'hFFFFFFFA, 32'hFFFFFFFF};
        tbl[2] = '{2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0, 4'd1, 4'd2, 3, 0, 1'b0, 32'h00000001, 32'hFFFFFFFE};
        tbl[3] = '{2'b10, 32'd10, 32'd20, 32'd0, 32'd5, 1'b0, 1'b1, 1'b0, 4'd7, 4'd0, 1, 1, 1'b0, 32'd205, 32'd0};
        tbl[4] = '{2'b01, 32'h10000, 32'h10000, 32'd1, 32'hFFFFFFFF, 1'b1, 1'b1, 1'b0, 4'd8, 4'd9, 4, 0, 1'b0, 32'hFFFFFFFF, 32'd2};
        tbl[5] = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'd0, 1'b1, 1'b0, 1'b1, 4'd6, 4'd6, 2, 2, 1'b1, 32'd1, 32'd0};
        tbl[6] = '{2'b11, 32'hFFFFFFFD, 32'd5, 32'd0, 32'd20, 1'b1, 1'b1, 1'b1, 4'd10, 4'd11, 2, 0, 1'b0, 32'd5, 32'd0};

        // Reset state, with both lanes requesting
        rst_n = 1'b0;
        req   = 2'b11;
        tick(); tick(); #3;
        chk("rst_gnt", gnt, 2'b00);
        chk("rst_ctl", {busy, wb_valid, mul_start, mul_long, mul_add, mul_signed}, 6'd0);
        chk("rst_ops", {mul_a, mul_b}, 64'd0);
        chk("rst_wb", {wb_r, wb_value}, 36'd0);
        tick();
        rst_n = 1'b1;
        req   = 2'b00;

        // Table-driven single operations
        for (int i = 0; i < 7; i++) begin
            tick();
            drive_op(tbl[i]);
            wait_grant(tbl[i]);
            finish_op(tbl[i], tbl[i].stall, tbl[i].flw);
        end

        // Both lanes request: lane 0 first, lane 1 the cycle after its ack
        tick();
        scramble();
        req = 2'b11; mul_lat = 2;
        op_a = {32'd3, 32'd7}; op_b = {32'd4, 32'd6};
        op_c_hi = '0; op_c_lo = '0; op_long = 2'b00; op_add = 2'b00; op_sig = 2'b00;
        op_rd_lo = {4'd2, 4'd3};
        #3;
        chk("both_gnt0", gnt, 2'b01);
        saw11 = 0; g1 = -1; ackc = -1;
        for (int i = 0; i < 40 && g1 < 0; i++) begin
            tick();
            req = 2'b10; wb_ack = 1'b0;
            #3;
            if (gnt == 2'b11) saw11 = 1;
            if (gnt == 2'b10) g1 = i;
            else if (wb_valid) begin
                ackc = i;
                chk("both_lane0_r", wb_r, 4'd3);
                chk("both_lane0_val", wb_value, 32'd42);
                wb_ack = 1'b1;
            end
        end
        chk("never_gnt11", saw11, 0);
        chk("lane1_next_cycle", g1, ackc + 1);
        t1 = '{2'b10, 32'd3, 32'd4, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 4'd2, 4'd0, 2, 0, 1'b0, 32'd12, 32'd0};
        finish_op(t1, 0, 1'b0);

        // Flush in ISSUE: one start pulse, then drain without writeback
        t = '{2'b01, 32'd5, 32'd5, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 4'd1, 4'd0, 2, 0, 1'b0, 32'd25, 32'd0};
        tick();
        drive_op(t);
        wait_grant(t);
        tick();
        req = 2'b00; flush = 1'b1;
        #3;
        chk("fi_start", mul_start, 1'b1);
        tick();
        flush = 1'b0;
        #3;
        chk("fi_start_gone", mul_start, 1'b0);
        chk("fi_busy", busy, 1'b1);
        starts = 0; seenwb = 0; c = 0;
        while (busy && c < 20) begin
            if (mul_start) starts++;
            if (wb_valid) seenwb = 1;
            tick(); #3; c++;
        end
        chk("fi_starts", starts, 0);
        chk("fi_no_wb", seenwb, 0);
        chk("fi_drain_len", c, 2);

        // Flush in WAIT, ready two cycles later; new request granted right after
        t = '{2'b10, 32'd9, 32'd9, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 4'd5, 4'd0, 3, 0, 1'b0, 32'd81, 32'd0};
        tick();
        drive_op(t);
        wait_grant(t);
        tick(); req = 2'b00; #3;
        tick(); flush = 1'b1; #3;
        chk("fw_wait_wb", wb_valid, 1'b0);
        tick(); flush = 1'b0; #3;
        chk("fw_drain", {busy, wb_valid}, 2'b10);
        t1 = '{2'b01, 32'd11, 32'd3, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 4'd6, 4'd0, 2, 0, 1'b0, 32'd33, 32'd0};
        tick();
        drive_op(t1);
        #3;
        chk("fw_ready_cycle", {busy, wb_valid, gnt}, 4'b1000);
        tick(); #3;
        chk("fw_busy_drop", busy, 1'b0);
        chk("fw_regrant", gnt, 2'b01);
        finish_op(t1, 1, 1'b0);

        // Reset while waiting on the multiplier
        t = '{2'b01, 32'd100, 32'd3, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0, 4'd2, 4'd3, 4, 0, 1'b0, 32'd300, 32'd0};
        tick();
        drive_op(t);
        wait_grant(t);
        tick(); req = 2'b00;
        tick(); rst_n = 1'b0;
        tick(); rst_n = 1'b1;
        t1 = '{2'b10, 32'd8, 32'd8, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 4'd9, 4'd0, 2, 0, 1'b0, 32'd64, 32'd0};
        drive_op(t1);
        #3;
        chk("rw_ctl", {busy, wb_valid, mul_start, mul_long, mul_add, mul_signed}, 6'd0);
        chk("rw_ops", {mul_a, mul_b, mul_c_hi, mul_c_lo}, 128'd0);
        chk("rw_wb", {wb_r, wb_value}, 36'd0);
        chk("rw_gnt", gnt, 2'b10);
        finish_op(t1, 0, 1'b0);

        // Randomised operations against the arithmetic reference
        for (int i = 0; i < 30; i++) begin
            case ($urandom_range(0, 2))
                0:       t.req = 2'b01;
                1:       t.req = 2'b10;
                default: t.req = 2'b11;
            endcase
            t.a = $urandom(); t.b = $urandom(); t.chi = $urandom(); t.clo = $urandom();
            t.lng = 1'($urandom_range(0, 1));
            t.add = 1'($urandom_range(0, 1));
            t.sig = 1'($urandom_range(0, 1));
            t.rlo = 4'($urandom_range(0, 15));
            t.rhi = 4'($urandom_range(0, 15));
            t.n   = $urandom_range(1, 4);
            t.stall = $urandom_range(0, 2);
            t.flw = 1'($urandom_range(0, 1));
            r = ref_mul(t.a, t.b, t.chi, t.clo, t.lng, t.add, t.sig);
            t.elo = r[31:0];
            t.ehi = r[63:32];
            tick();
            drive_op(t);
            wait_grant(t);
            finish_op(t, t.stall, t.flw);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
